ecc_point_unit: RTL and testbench
=================================

Name: ecc_point_unit

Overview:
- Parametrised affine point-arithmetic unit for the non-supersingular binary curve y^2 + xy = x^3 + A*x^2 + B over GF(2^M).
- An explicit opcode selects add, double, subtract or negate, replacing in-band flag bits. The width, reduction polynomial and curve coefficient A are parameters.
- Sits below the scalar-multiply controller. It uses one shared bit-serial GF(2^M) multiplier and computes inversion by Fermat exponentiation.

Parameters:
- M, 79: field degree; width of every coordinate.
- POLY, 80'h8000_0000_0000_0000_0201: reduction polynomial, M+1 bits, bit M set.
- A, 0: curve coefficient a, M bits. B must be nonzero; B is not used by the formulas.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  2  00 add P+Q, 01 double 2P, 10 subtract P-Q, 11 negate -P.
- px, py, qx, qy  in  M each  operand coordinates. (0,0) encodes the point at infinity O.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high from the cycle after accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse; rx/ry are valid from that cycle.
- rx, ry  out  M each  result coordinates; (0,0) = O.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, rx=0, ry=0. The multiplier and exponent counters are cleared.
- Operand capture: on a clk edge with start=1 in IDLE, latch op and all four operands. Later input changes have no effect.
- start while busy: ignored, no queuing.
- Field arithmetic:
  - Addition is XOR.
  - Multiply is bit-serial, MSB-first, with interleaved reduction by POLY: M cycles plus 1 load cycle. Squaring uses the same multiplier.
  - Inverse of a is a^(2^M-2): M-1 squarings interleaved with M-2 multiplies.
- Negation: -(x,y) = (x, x^y). Subtract internally uses Q' = (qx, qx^qy) and then follows the add path. O negates to O.
- FSM states: IDLE -> PREP -> {INV -> LAM -> X3 -> Y3} -> FIN -> IDLE.
- PREP, one cycle, resolves special cases in this priority order:
  - negate: R = -P -> FIN.
  - double with P=O or px=0: R = O -> FIN.
  - add/sub with P=O: R = Q' -> FIN.
  - add/sub with Q'=O: R = P -> FIN.
  - add/sub with px=qx' and py=qy': treat as double.
  - add/sub with px=qx', y differs: R = O -> FIN.
  - otherwise: INV with denominator d = px^qx' (add) or d = px (double).
- Add path: lam = (py^qy')*d^-1; x3 = lam^2 ^ lam ^ px ^ qx' ^ A; y3 = lam*(px^x3) ^ x3 ^ py.
- Double path: lam = px ^ py*d^-1; x3 = lam^2 ^ lam ^ A; y3 = px^2 ^ (lam^1)*x3.
- FIN: register rx/ry, assert done for one cycle, drop busy the next cycle.
- Latency, start edge to done:
  - special cases: exactly 3 cycles.
  - general case: at most 2*(M+2)^2 cycles. Latency depends only on the path taken, never on operand values.
- Output hold: rx/ry hold until the next done or reset. They are not cleared at start.
- Reset mid-operation: abort immediately, zero the outputs, no done pulse. The first start after release is accepted normally.
- start asserted in the done cycle: ignored. The unit is in IDLE only from the following cycle.

Test Plan (M=3, POLY=4'b1011, A=0, B=1 unless stated):
- Add: op=00, P=(1,0), Q=(0,1), start 1 cycle -> done once within 50 cycles; R=(1,1); busy low after.
- Double and special cases: op=01, P=(1,0) -> R=(0,1). op=01, P=(0,1) -> R=(0,0) with done exactly 3 cycles after start.
- Subtract and negate: op=10, P=(0,1), Q=(1,0) -> R=(1,0). op=11, P=(1,0) -> R=(1,1). op=10, P=Q=(1,1) -> R=(0,0).
- Infinity handling: op=00, P=(0,0), Q=(1,1) -> R=(1,1). op=00, P=(1,0), Q=(0,0) -> R=(1,0). op=00, P=Q=(1,0) -> R=(0,1) via the double path.
- Handshake and reset: start held high for 5 cycles -> exactly one done. During a busy add, pull reset low for 1 cycle -> busy=0, rx=ry=0, no done. A new op=01, P=(1,0) then yields (0,1).
- Default parameters (M=79): add P=(30CB127B63E42792F10F, 547B2C88266BB04F713B), Q=(00202A9F035014497325, 5175A64859552F97C129) -> R matches the golden model; done within 2*81^2 cycles. Subtract P-Q from that result -> returns the original P.

Source files
------------

// File: rtl/ecc_point_unit.sv
// Affine point add/double/subtract/negate on y^2 + xy = x^3 + A*x^2 + B over GF(2^M),
// built around one shared bit-serial multiplier; inversion is a^(2^M-2).
module ecc_point_unit #(
  parameter int unsigned    M    = 79,
  parameter logic [M:0]     POLY = 80'h8000_0000_0000_0000_0201,
  parameter logic [M-1:0]   A    = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   op,
  input  logic [M-1:0] px,
  input  logic [M-1:0] py,
  input  logic [M-1:0] qx,
  input  logic [M-1:0] qy,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] rx,
  output logic [M-1:0] ry,
  output logic [2:0]   dbg_state
);

  // Handshake: start is sampled only in IDLE; busy rises the cycle after an
  // accepted start and stays high through the one-cycle done pulse; rx/ry are
  // valid from the done cycle and hold until the next done or reset.

  localparam int unsigned CW     = $clog2(M + 1);
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_DBL = 2'b01;
  localparam logic [1:0]  OP_SUB = 2'b10;
  localparam logic [1:0]  OP_NEG = 2'b11;
  localparam logic [M-1:0] ONE   = {{(M-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_INV  = 3'd2,
    S_LAM  = 3'd3,
    S_X3   = 3'd4,
    S_Y3   = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t         state_q;
  logic [1:0]     op_q;
  logic [M-1:0]   px_q, py_q, qx_q, qy_q;
  logic           dbl_q, phase_q, busy_q, done_q;
  logic [CW-1:0]  exp_q, mul_cnt_q;
  logic [M-1:0]   mul_a_q, mul_b_q, mul_acc_q;
  logic [M-1:0]   d_q, lam_q, x3_q, tmp_q;
  logic [M-1:0]   res_x_q, res_y_q, rx_q, ry_q;

  logic [M-1:0]   mul_d, lam_d, x3_d;
  logic           mul_ld;
  logic [M-1:0]   ld_a, ld_b;
  logic           p_inf, q_inf, same_x, same_y;
  logic           prep_fin, prep_dbl;
  logic [M-1:0]   prep_rx, prep_ry, prep_d;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rx        = rx_q;
  assign ry        = ry_q;
  assign dbg_state = state_q;

  // One MSB-first step: acc = acc*x mod POLY, plus a when the current b bit is set.
  always_comb begin
    mul_d = {mul_acc_q[M-2:0], 1'b0} ^ (mul_acc_q[M-1] ? POLY[M-1:0] : '0)
            ^ (mul_b_q[M-1] ? mul_a_q : '0);
    lam_d = mul_acc_q ^ (dbl_q ? px_q : '0);
    x3_d  = mul_acc_q ^ lam_q ^ A ^ (dbl_q ? '0 : (px_q ^ qx_q));
  end

  // Special-case resolution; qy_q already holds the negated y for subtract.
  always_comb begin
    p_inf    = (px_q == '0) && (py_q == '0);
    q_inf    = (qx_q == '0) && (qy_q == '0);
    same_x   = (px_q == qx_q);
    same_y   = (py_q == qy_q);
    prep_fin = 1'b1;
    prep_dbl = 1'b0;
    prep_rx  = '0;
    prep_ry  = '0;
    prep_d   = px_q;
    if (op_q == OP_NEG) begin
      prep_rx = px_q;
      prep_ry = px_q ^ py_q;
    end else if (op_q == OP_DBL || (!p_inf && !q_inf && same_x && same_y)) begin
      if (px_q != '0) begin
        prep_fin = 1'b0;
        prep_dbl = 1'b1;
      end
    end else if (p_inf) begin
      prep_rx = qx_q;
      prep_ry = qy_q;
    end else if (q_inf) begin
      prep_rx = px_q;
      prep_ry = py_q;
    end else if (!same_x) begin
      prep_fin = 1'b0;
      prep_d   = px_q ^ qx_q;
    end
  end

  // Next multiplier job, issued in the same cycle the previous product is consumed.
  always_comb begin
    mul_ld = 1'b0;
    ld_a   = '0;
    ld_b   = '0;
    if (mul_cnt_q == '0) begin
      case (state_q)
        S_PREP: begin
          mul_ld = !prep_fin;
          ld_a   = prep_d;
          ld_b   = prep_d;
        end
        S_INV: begin
          mul_ld = 1'b1;
          if (phase_q) begin
            ld_a = mul_acc_q;
            ld_b = mul_acc_q;
          end else if (exp_q != '0) begin
            ld_a = mul_acc_q;
            ld_b = d_q;
          end else begin
            ld_a = dbl_q ? py_q : (py_q ^ qy_q);
            ld_b = mul_acc_q;
          end
        end
        S_LAM: begin
          mul_ld = 1'b1;
          ld_a   = lam_d;
          ld_b   = lam_d;
        end
        S_X3: begin
          mul_ld = 1'b1;
          ld_a   = dbl_q ? (lam_q ^ ONE) : lam_q;
          ld_b   = dbl_q ? x3_d : (px_q ^ x3_d);
        end
        S_Y3: begin
          mul_ld = dbl_q && !phase_q;
          ld_a   = px_q;
          ld_b   = px_q;
        end
        default: mul_ld = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      px_q      <= '0;
      py_q      <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      dbl_q     <= 1'b0;
      phase_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exp_q     <= '0;
      mul_cnt_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_acc_q <= '0;
      d_q       <= '0;
      lam_q     <= '0;
      x3_q      <= '0;
      tmp_q     <= '0;
      res_x_q   <= '0;
      res_y_q   <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
    end else if (mul_cnt_q != '0) begin
      mul_acc_q <= mul_d;
      mul_b_q   <= {mul_b_q[M-2:0], 1'b0};
      mul_cnt_q <= mul_cnt_q - CW'(1);
    end else begin
      if (mul_ld) begin
        mul_a_q   <= ld_a;
        mul_b_q   <= ld_b;
        mul_acc_q <= '0;
        mul_cnt_q <= CW'(M);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            px_q    <= px;
            py_q    <= py;
            qx_q    <= qx;
            qy_q    <= (op == OP_SUB) ? (qx ^ qy) : qy;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (prep_fin) begin
            res_x_q <= prep_rx;
            res_y_q <= prep_ry;
            state_q <= S_FIN;
          end else begin
            dbl_q   <= prep_dbl;
            d_q     <= prep_d;
            phase_q <= 1'b0;
            exp_q   <= CW'(M - 2);
            state_q <= S_INV;
          end
        end
        // Alternates square / multiply-by-d until M-1 squarings are done.
        S_INV: begin
          if (phase_q) begin
            phase_q <= 1'b0;
          end else if (exp_q != '0) begin
            phase_q <= 1'b1;
            exp_q   <= exp_q - CW'(1);
          end else begin
            state_q <= S_LAM;
          end
        end
        S_LAM: begin
          lam_q   <= lam_d;
          state_q <= S_X3;
        end
        S_X3: begin
          x3_q    <= x3_d;
          phase_q <= 1'b0;
          state_q <= S_Y3;
        end
        S_Y3: begin
          if (!dbl_q) begin
            res_x_q <= x3_q;
            res_y_q <= mul_acc_q ^ x3_q ^ py_q;
            state_q <= S_FIN;
          end else if (!phase_q) begin
            tmp_q   <= mul_acc_q;
            phase_q <= 1'b1;
          end else begin
            res_x_q <= x3_q;
            res_y_q <= mul_acc_q ^ tmp_q;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          if (!done_q) begin
            rx_q   <= res_x_q;
            ry_q   <= res_y_q;
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_unit.sv
// Bench for ecc_point_unit: a GF(2^3) instance with known answers and a GF(2^79)
// instance checked against a software field model.
module tb_ecc_point_unit;

  localparam int SM = 3;
  localparam int BM = 79;
  localparam int W  = 158;
  localparam logic [BM:0] BPOLY = 80'h8000_0000_0000_0000_0201;
  localparam int BIG_BUDGET = 2 * (BM + 2) * (BM + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]    s_op;
  logic [SM-1:0] s_px, s_py, s_qx, s_qy, s_rx, s_ry;
  logic          s_start, s_busy, s_done;
  logic [2:0]    s_dbg;

  logic [1:0]    b_op;
  logic [BM-1:0] b_px, b_py, b_qx, b_qy, b_rx, b_ry;
  logic          b_start, b_busy, b_done;
  logic [2:0]    b_dbg;

  ecc_point_unit #(.M(SM), .POLY(4'b1011), .A(3'b000)) u_small (
    .clk(clk), .reset(rst_n), .op(s_op), .px(s_px), .py(s_py), .qx(s_qx), .qy(s_qy),
    .start(s_start), .busy(s_busy), .done(s_done), .rx(s_rx), .ry(s_ry), .dbg_state(s_dbg)
  );

  ecc_point_unit u_big (
    .clk(clk), .reset(rst_n), .op(b_op), .px(b_px), .py(b_py), .qx(b_qx), .qy(b_qy),
    .start(b_start), .busy(b_busy), .done(b_done), .rx(b_rx), .ry(b_ry), .dbg_state(b_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*SM-1:0] exp_q[$];
  string           tag_q[$];
  logic [2*SM-1:0] last_res;
  int              s_done_cnt = 0;
  int              s_done_cyc = 0;

  logic [2*BM-1:0] exp_big_q[$];
  string           btag_q[$];
  int              b_done_cnt = 0;
  int              b_done_cyc = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // GF(2^79) reference: schoolbook product then reduction from the top bit down.
  function automatic logic [BM-1:0] gf_mul_ref(input logic [BM-1:0] a, input logic [BM-1:0] b);
    logic [2*BM-2:0] p;
    p = '0;
    for (int i = 0; i < BM; i++)
      if (b[i]) p = p ^ ({{(BM-1){1'b0}}, a} << i);
    for (int j = 2*BM-2; j >= BM; j--)
      if (p[j]) p = p ^ ({{(BM-2){1'b0}}, BPOLY} << (j - BM));
    return p[BM-1:0];
  endfunction

  function automatic logic [BM-1:0] gf_inv_ref(input logic [BM-1:0] a);
    logic [BM-1:0] r, base;
    r    = '0;
    r[0] = 1'b1;
    base = a;
    for (int i = 1; i < BM; i++) begin
      base = gf_mul_ref(base, base);
      r    = gf_mul_ref(r, base);
    end
    return r;
  endfunction

  function automatic logic [2*BM-1:0] add_ref(input logic [BM-1:0] x1, input logic [BM-1:0] y1,
                                              input logic [BM-1:0] x2, input logic [BM-1:0] y2);
    logic [BM-1:0] lam, x3, y3;
    lam = gf_mul_ref(y1 ^ y2, gf_inv_ref(x1 ^ x2));
    x3  = gf_mul_ref(lam, lam) ^ lam ^ x1 ^ x2;
    y3  = gf_mul_ref(lam, x1 ^ x3) ^ x3 ^ y1;
    return {x3, y3};
  endfunction

  always @(negedge clk) begin
    if (rst_n && s_done) begin
      s_done_cnt++;
      s_done_cyc = cyc;
      check_eq("sm_sb_pending", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        check_eq(tag_q[0], W'({s_rx, s_ry}), W'(exp_q[0]));
        check_eq({tag_q[0], "_busy_in_done"}, W'(s_busy), W'(1));
        last_res = exp_q[0];
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
      end
    end
    if (rst_n && b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
      check_eq("big_sb_pending", W'(exp_big_q.size() != 0), W'(1));
      if (exp_big_q.size() != 0) begin
        check_eq(btag_q[0], W'({b_rx, b_ry}), W'(exp_big_q[0]));
        void'(exp_big_q.pop_front());
        void'(btag_q.pop_front());
      end
    end
  end

  task automatic run_small(input logic [1:0] o, input logic [SM-1:0] ax, input logic [SM-1:0] ay,
                           input logic [SM-1:0] bx, input logic [SM-1:0] by,
                           input logic [2*SM-1:0] e, input string tag, input int hold,
                           output int lat);
    int base, st, waited;
    @(negedge clk);
    s_op = o; s_px = ax; s_py = ay; s_qx = bx; s_qy = by; s_start = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    base = s_done_cnt;
    st   = cyc;
    repeat (hold) @(negedge clk);
    s_start = 1'b0;
    s_op = 2'($urandom_range(0, 3));
    s_px = 3'($urandom_range(0, 7)); s_py = 3'($urandom_range(0, 7));
    s_qx = 3'($urandom_range(0, 7)); s_qy = 3'($urandom_range(0, 7));
    check_eq({tag, "_hold_out"}, W'({s_rx, s_ry}), W'(last_res));
    waited = 0;
    while (s_done_cnt == base && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    check_eq({tag, "_done_seen"}, W'(s_done_cnt != base), W'(1));
    lat = s_done_cyc - st;
    @(negedge clk);
    check_eq({tag, "_busy_after"}, W'(s_busy), W'(0));
  endtask

  task automatic run_big(input logic [1:0] o, input logic [BM-1:0] ax, input logic [BM-1:0] ay,
                         input logic [BM-1:0] bx, input logic [BM-1:0] by,
                         input logic [2*BM-1:0] e, input string tag);
    int base, st, waited;
    @(negedge clk);
    b_op = o; b_px = ax; b_py = ay; b_qx = bx; b_qy = by; b_start = 1'b1;
    exp_big_q.push_back(e);
    btag_q.push_back(tag);
    base = b_done_cnt;
    st   = cyc;
    @(negedge clk);
    b_start = 1'b0;
    b_px = {$urandom, $urandom, $urandom};
    b_qy = {$urandom, $urandom, $urandom};
    waited = 0;
    while (b_done_cnt == base && waited < BIG_BUDGET + 200) begin
      @(posedge clk);
      waited++;
    end
    check_eq({tag, "_done_seen"}, W'(b_done_cnt != base), W'(1));
    check_eq({tag, "_lat_in_budget"}, W'((b_done_cyc - st) <= BIG_BUDGET), W'(1));
    @(negedge clk);
    check_eq({tag, "_busy_after"}, W'(b_busy), W'(0));
  endtask

  localparam logic [BM-1:0] PX = 79'h30CB127B63E42792F10F;
  localparam logic [BM-1:0] PY = 79'h547B2C88266BB04F713B;
  localparam logic [BM-1:0] QX = 79'h00202A9F035014497325;
  localparam logic [BM-1:0] QY = 79'h5175A64859552F97C129;

  initial begin
    int lat, base;
    logic [SM-1:0] rxv, ryv;
    logic [2*BM-1:0] r_big;
    rst_n = 1'b0;
    s_op = '0; s_px = '0; s_py = '0; s_qx = '0; s_qy = '0; s_start = 1'b0;
    b_op = '0; b_px = '0; b_py = '0; b_qx = '0; b_qy = '0; b_start = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_small_outputs", W'({s_busy, s_done, s_rx, s_ry}), W'(0));
    check_eq("rst_small_state", W'(s_dbg), W'(0));
    check_eq("rst_big_outputs", W'({b_busy, b_done, b_rx, b_ry}), W'(0));
    rst_n = 1'b1;

    run_small(2'b00, 3'd1, 3'd0, 3'd0, 3'd1, {3'd1, 3'd1}, "add_basic", 1, lat);
    check_eq("add_basic_lat_le_50", W'(lat <= 50), W'(1));
    run_small(2'b01, 3'd1, 3'd0, 3'd0, 3'd0, {3'd0, 3'd1}, "dbl_basic", 1, lat);
    run_small(2'b01, 3'd0, 3'd1, 3'd0, 3'd0, {3'd0, 3'd0}, "dbl_x0", 1, lat);
    check_eq("dbl_x0_lat", W'(lat), W'(3));
    run_small(2'b10, 3'd0, 3'd1, 3'd1, 3'd0, {3'd1, 3'd0}, "sub_basic", 1, lat);
    run_small(2'b11, 3'd1, 3'd0, 3'd5, 3'd6, {3'd1, 3'd1}, "neg_basic", 1, lat);
    check_eq("neg_lat", W'(lat), W'(3));
    run_small(2'b10, 3'd1, 3'd1, 3'd1, 3'd1, {3'd0, 3'd0}, "sub_self", 1, lat);
    run_small(2'b00, 3'd0, 3'd0, 3'd1, 3'd1, {3'd1, 3'd1}, "add_p_inf", 1, lat);
    check_eq("add_p_inf_lat", W'(lat), W'(3));
    run_small(2'b00, 3'd1, 3'd0, 3'd0, 3'd0, {3'd1, 3'd0}, "add_q_inf", 1, lat);
    run_small(2'b00, 3'd1, 3'd0, 3'd1, 3'd0, {3'd0, 3'd1}, "add_equal", 1, lat);

    for (int i = 0; i < 4; i++) begin
      rxv = 3'($urandom_range(0, 7));
      ryv = 3'($urandom_range(0, 7));
      run_small(2'b11, rxv, ryv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                {rxv, rxv ^ ryv}, "neg_rand", 1, lat);
      run_small(2'b10, rxv, ryv, rxv, ryv, {3'd0, 3'd0}, "sub_rand_self", 1, lat);
    end

    base = s_done_cnt;
    run_small(2'b00, 3'd1, 3'd0, 3'd0, 3'd1, {3'd1, 3'd1}, "add_start_held", 5, lat);
    repeat (40) @(negedge clk);
    check_eq("start_held_one_done", W'(s_done_cnt - base), W'(1));

    @(negedge clk);
    s_op = 2'b00; s_px = 3'd1; s_py = 3'd0; s_qx = 3'd0; s_qy = 3'd1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid_busy_before", W'(s_busy), W'(1));
    base  = s_done_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outputs", W'({s_busy, s_done, s_rx, s_ry}), W'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    last_res = '0;
    repeat (60) @(negedge clk);
    check_eq("rst_mid_no_done", W'(s_done_cnt - base), W'(0));
    run_small(2'b01, 3'd1, 3'd0, 3'd0, 3'd0, {3'd0, 3'd1}, "dbl_after_rst", 1, lat);

    r_big = add_ref(PX, PY, QX, QY);
    run_big(2'b00, PX, PY, QX, QY, r_big, "big_add");
    run_big(2'b10, r_big[2*BM-1:BM], r_big[BM-1:0], QX, QY,
            add_ref(r_big[2*BM-1:BM], r_big[BM-1:0], QX, QX ^ QY), "big_sub");

    repeat (5) @(negedge clk);
    check_eq("sm_queue_drained", W'(exp_q.size()), W'(0));
    check_eq("big_queue_drained", W'(exp_big_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
